// File: rtl/pong_game_controller_pkg.sv
// pong_game_controller_pkg: game state encoding and output field widths shared by the pong controller.
package pong_game_controller_pkg;
    localparam int GAME_STATE_W = 3;
    localparam int SCORE_W = 4;
    localparam int LIVES_W = 2;
    typedef enum logic [GAME_STATE_W-1:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        LOSE  = 3'd3,
        WIN   = 3'd4
    } gameState_t;
endpackage

// File: rtl/pong_game_controller_debounce.sv
// pong_game_controller_debounce: 2-FF synchroniser plus stable-sample counter for one raw active-low button.
module pong_game_controller_debounce #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    logic [1:0] sync;
    logic [CNT_W-1:0] count;
    // count runs only while the synchronised sample differs from the accepted level
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync <= 2'b11;
            count <= '0;
            level <= 1'b1;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == level) count <= '0;
            else if (count == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync[1];
                count <= '0;
            end else count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/pong_game_controller.sv
// pong_game_controller: debounces buttons, paces paddle moves with a tick and runs the serve/play/point game FSM.
module pong_game_controller
    import pong_game_controller_pkg::*;
#(
    parameter int CLOCK_FREQ      = 50_000_000,
    parameter int MOVE_RATE_HZ    = 100,
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int SERVE_TICKS     = 100,
    parameter int WIN_SCORE       = 5,
    parameter int LIVES           = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [1:0]              button,
    input  logic                    buttonStart,
    input  logic                    ballHit,
    input  logic                    ballMissed,
    output logic [1:0]              paddleButton,
    output logic                    paddleReset,
    output logic                    moveTick,
    output logic [GAME_STATE_W-1:0] gameState,
    output logic [SCORE_W-1:0]      score,
    output logic [LIVES_W-1:0]      lives,
    output logic                    gameOver
);
    localparam int TICK_DIV = CLOCK_FREQ / MOVE_RATE_HZ;
    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int SERVE_W = $clog2(SERVE_TICKS + 1);
    logic [2:0] rawIn, deb;
    logic [TICK_W-1:0] tickCount;
    logic [SERVE_W-1:0] serveCount;
    logic tickLast, startPrev, startPress;
    gameState_t state;
    assign rawIn = {buttonStart, button};
    for (genvar i = 0; i < 3; i++) begin : g_deb
        pong_game_controller_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clock(clock),
            .reset(reset),
            .raw(rawIn[i]),
            .level(deb[i])
        );
    end
    assign tickLast = tickCount == TICK_W'(TICK_DIV - 1);
    assign startPress = startPrev & ~deb[2];
    assign gameState = state;
    // both buttons held cancel out so the paddle never gets a conflicting request
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tickCount <= '0;
            moveTick <= 1'b0;
            paddleButton <= 2'b11;
        end else begin
            moveTick <= tickLast;
            tickCount <= tickLast ? '0 : tickCount + 1'b1;
            paddleButton <= (state == PLAY && tickLast && deb[1:0] != 2'b00) ? deb[1:0] : 2'b11;
        end
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            score <= '0;
            lives <= LIVES_W'(LIVES);
            serveCount <= '0;
            paddleReset <= 1'b1;
            gameOver <= 1'b0;
            startPrev <= 1'b1;
        end else begin
            startPrev <= deb[2];
            case (state)
                IDLE, LOSE, WIN: if (startPress) begin
                    state <= SERVE;
                    score <= '0;
                    lives <= LIVES_W'(LIVES);
                    serveCount <= '0;
                    gameOver <= 1'b0;
                end
                SERVE: if (moveTick) begin
                    if (serveCount == SERVE_W'(SERVE_TICKS - 1)) begin
                        state <= PLAY;
                        serveCount <= '0;
                        paddleReset <= 1'b0;
                    end else serveCount <= serveCount + 1'b1;
                end
                // a miss takes priority over a simultaneous hit
                PLAY: if (ballMissed) begin
                    lives <= lives - 1'b1;
                    paddleReset <= 1'b1;
                    state <= (lives == LIVES_W'(1)) ? LOSE : SERVE;
                    gameOver <= lives == LIVES_W'(1);
                end else if (ballHit) begin
                    score <= score + 1'b1;
                    if (score == SCORE_W'(WIN_SCORE - 1)) begin
                        state <= WIN;
                        gameOver <= 1'b1;
                        paddleReset <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
